// File: rtl/serial_loader_if.sv
// rtl/serial_loader_if.sv - mode/serial-data inputs and program-memory write port of serial_loader
interface serial_loader_if #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]        mode_in;
    logic              mosi_in;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              done_out;
    logic              run_en;
    logic              err_out;

    modport slave (
        input  mode_in, mosi_in,
        output mem_we, mem_addr, mem_wdata, done_out, run_en, err_out
    );

    modport master (
        output mode_in, mosi_in,
        input  mem_we, mem_addr, mem_wdata, done_out, run_en, err_out
    );
endinterface

// File: rtl/serial_loader.sv
// rtl/serial_loader.sv - serial program-image loader (MSB-first frames into program memory)
// Define LOADER_PARITY_EN to append an even-parity bit to every frame.
module serial_loader #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic           clk,
    input  logic           rst,
    serial_loader_if.slave bus
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef LOADER_PARITY_EN
    localparam int FRAME_W = WORD_W + 1;
`else
    localparam int FRAME_W = WORD_W;
`endif
    localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              run_q, run_d;
    logic              err_q, err_d;

    logic [WORD_W-1:0] frame_word;
    logic              frame_ok;
    logic              load_req, run_req, last_bit;

    // With parity the data bits are already shifted in when the parity bit arrives.
`ifdef LOADER_PARITY_EN
    assign frame_word = shift_q;
    assign frame_ok   = ~(^{shift_q, bus.mosi_in});
`else
    assign frame_word = {shift_q[WORD_W-2:0], bus.mosi_in};
    assign frame_ok   = 1'b1;
`endif

    assign load_req = (bus.mode_in == 2'b01);
    assign run_req  = (bus.mode_in == 2'b10);
    assign last_bit = (bit_cnt_q == CNT_W'(FRAME_W - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        we_d      = 1'b0;
        maddr_d   = maddr_q;
        wdata_d   = wdata_q;
        done_d    = done_q;
        run_d     = 1'b0;
        err_d     = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_req) begin
                    state_d   = S_LOAD;
                    bit_cnt_d = '0;
                    addr_d    = '0;
                    shift_d   = '0;
                    err_d     = 1'b0;
                    done_d    = 1'b0;
                end else if (state_q == S_DONE && run_req) begin
                    run_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (!load_req) begin
                    // Abandon the partial frame; nothing reaches memory.
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    done_d    = 1'b0;
                end else if (!last_bit) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    shift_d   = {shift_q[WORD_W-2:0], bus.mosi_in};
                end else begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    if (frame_ok) begin
                        we_d    = 1'b1;
                        wdata_d = frame_word;
                        maddr_d = addr_q;
                        if (addr_q == ADDR_W'(DEPTH - 1)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            shift_q   <= '0;
            we_q      <= 1'b0;
            maddr_q   <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            run_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            we_q      <= we_d;
            maddr_q   <= maddr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            run_q     <= run_d;
            err_q     <= err_d;
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.done_out  = done_q;
    assign bus.run_en    = run_q;
    assign bus.err_out   = err_q;
endmodule
